uart_rx_frame: RTL and testbench

Parametrised UART receiver, the next-generation serial-input block. It supports 5–9 data bits, no/even/odd parity and 1 or 2 stop bits, and adds a synchronous reset. It reports parity error, framing error and break alongside each received word. It sits directly behind the device pin and feeds word-level consumers (command decoders, FIFOs) with a one-cycle valid strobe.

---
 rtl/uart_rx_frame.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// UART receiver: 5..9 data bits, optional even/odd parity, 1 or 2 stop bits.
// Reports parity error, framing error and break with a one-cycle valid strobe.
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Word,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Busy
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] HALF     = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_DAT = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STP = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_CLEANUP, S_WAIT_HIGH
    } state_t;

    state_t               state_q, state_d;
    logic                 meta_q, sync_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] word_q, word_d;
    logic                 par_q, par_d;
    logic                 ferr_q, ferr_d;
    logic                 one_q, one_d;
    logic                 dv_q, dv_d;
    logic [DATA_BITS-1:0] rx_word_q, rx_word_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ferr_out_q, ferr_out_d;
    logic                 brk_out_q, brk_out_d;
    logic                 busy_q, busy_d;
    logic                 bit_tick;

    // par_acc is the XOR of all data bits and the received parity bit
    function automatic logic parity_err(input logic par_acc);
        case (PARITY)
            1:       parity_err = par_acc;
            2:       parity_err = ~par_acc;
            default: parity_err = 1'b0;
        endcase
    endfunction

    assign bit_tick = (cnt_q == LAST_CNT);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        word_d     = word_q;
        par_d      = par_q;
        ferr_d     = ferr_q;
        one_d      = one_q;
        dv_d       = 1'b0;
        rx_word_d  = rx_word_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        brk_out_d  = brk_out_q;
        busy_d     = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                idx_d  = '0;
                word_d = '0;
                par_d  = 1'b0;
                ferr_d = 1'b0;
                one_d  = 1'b0;
                if (!sync_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    state_d = sync_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    cnt_d  = '0;
                    // LSB arrives first, so shift in from the top
                    word_d = {sync_q, word_q[DATA_BITS-1:1]};
                    par_d  = par_q ^ sync_q;
                    one_d  = one_q | sync_q;
                    if (idx_q == LAST_DAT) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    par_d   = par_q ^ sync_q;
                    one_d   = one_q | sync_q;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_tick) begin
                    cnt_d  = '0;
                    ferr_d = ferr_q | ~sync_q;
                    one_d  = one_q | sync_q;
                    if (idx_q == LAST_STP) begin
                        idx_d      = '0;
                        dv_d       = 1'b1;
                        rx_word_d  = word_q;
                        perr_out_d = parity_err(par_q);
                        ferr_out_d = ferr_q | ~sync_q;
                        brk_out_d  = ~(one_q | sync_q);
                        state_d    = S_CLEANUP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CLEANUP: begin
                // A bad frame with the line still low is treated as a break in progress
                state_d = (ferr_out_q && !sync_q) ? S_WAIT_HIGH : S_IDLE;
            end
            S_WAIT_HIGH: begin
                if (sync_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            meta_q     <= 1'b1;
            sync_q     <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            dv_q       <= 1'b0;
            rx_word_q  <= '0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            brk_out_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            meta_q     <= i_Rx_Serial;
            sync_q     <= meta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            dv_q       <= dv_d;
            rx_word_q  <= rx_word_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            brk_out_q  <= brk_out_d;
            busy_q     <= busy_d;
        end
        // Frame accumulators are cleared in IDLE before use
        word_q <= word_d;
        par_q  <= par_d;
        ferr_q <= ferr_d;
        one_q  <= one_d;
    end

    assign o_Rx_DV      = dv_q;
    assign o_Rx_Word    = rx_word_q;
    assign o_Parity_Err = perr_out_q;
    assign o_Frame_Err  = ferr_out_q;
    assign o_Break      = brk_out_q;
    assign o_Busy       = busy_q;
endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: four configurations (8N1, 8E1, 7O2, 9N1)
// share one stimulus line; expected words are queued when a frame is driven.
module tb_uart_rx_frame;
    logic        clk = 1'b0;
    logic        rst;
    logic        rx_line;
    int          sel;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int cpb   [4] = '{16, 16, 16, 1000};
    int dbits [4] = '{8, 8, 7, 9};
    int pmode [4] = '{0, 1, 2, 0};
    int nstop [4] = '{1, 1, 2, 1};

    logic       rx   [4];
    logic       dv   [4];
    logic       perr [4];
    logic       ferr [4];
    logic       brk  [4];
    logic       busy [4];
    logic [7:0] word0, word1;
    logic [6:0] word2;
    logic [8:0] word3;
    logic [8:0] wordx [4];

    assign rx[0] = (sel == 0) ? rx_line : 1'b1;
    assign rx[1] = (sel == 1) ? rx_line : 1'b1;
    assign rx[2] = (sel == 2) ? rx_line : 1'b1;
    assign rx[3] = (sel == 3) ? rx_line : 1'b1;
    assign wordx[0] = {1'b0, word0};
    assign wordx[1] = {1'b0, word1};
    assign wordx[2] = {2'b00, word2};
    assign wordx[3] = word3;

    uart_rx_frame #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[0]), .o_Rx_DV(dv[0]), .o_Rx_Word(word0),
        .o_Parity_Err(perr[0]), .o_Frame_Err(ferr[0]), .o_Break(brk[0]), .o_Busy(busy[0]));
    uart_rx_frame #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[1]), .o_Rx_DV(dv[1]), .o_Rx_Word(word1),
        .o_Parity_Err(perr[1]), .o_Frame_Err(ferr[1]), .o_Break(brk[1]), .o_Busy(busy[1]));
    uart_rx_frame #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7o2 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[2]), .o_Rx_DV(dv[2]), .o_Rx_Word(word2),
        .o_Parity_Err(perr[2]), .o_Frame_Err(ferr[2]), .o_Break(brk[2]), .o_Busy(busy[2]));
    uart_rx_frame #(.CLKS_PER_BIT(1000), .DATA_BITS(9), .PARITY(0), .STOP_BITS(1)) u_9n1 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[3]), .o_Rx_DV(dv[3]), .o_Rx_Word(word3),
        .o_Parity_Err(perr[3]), .o_Frame_Err(ferr[3]), .o_Break(brk[3]), .o_Busy(busy[3]));

    typedef struct {
        int          inst;
        logic [8:0]  word;
        logic        perr;
        logic        ferr;
        logic        brk;
        int unsigned exp_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   prev_dv [4];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every strobe is matched against the oldest queued frame
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (dv[i]) begin
                chk("dv_consecutive", 32'(prev_dv[i]), 32'd0);
                if (sb.size() == 0) begin
                    chk("spurious_dv", 32'(dv[i]), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("dv_instance", i, mon_e.inst);
                    chk("dv_cycle", cyc, mon_e.exp_cyc);
                    chk("rx_word", 32'(wordx[i]), 32'(mon_e.word));
                    chk("parity_err", 32'(perr[i]), 32'(mon_e.perr));
                    chk("frame_err", 32'(ferr[i]), 32'(mon_e.ferr));
                    chk("break", 32'(brk[i]), 32'(mon_e.brk));
                end
            end
            prev_dv[i] = dv[i];
        end
    end

    // Called on a falling edge; drives one full frame on DUT i
    task automatic send_frame(input int i, input logic [8:0] data, input bit flip_par,
                              input logic [1:0] stops, input int tail_low, input bit expect_it);
        int         c, nb, pm, ns, n, h;
        logic       x, pb, all_stop_low;
        logic [8:0] masked;
        exp_t       e;
        c  = cpb[i];
        nb = dbits[i];
        pm = pmode[i];
        ns = nstop[i];
        n  = nb + ((pm != 0) ? 1 : 0) + ns;
        h  = (c - 1) / 2;
        x  = 1'b0;
        masked = '0;
        for (int k = 0; k < nb; k++) begin
            x = x ^ data[k];
            masked[k] = data[k];
        end
        pb = (pm == 2) ? ~x : x;
        if (flip_par) pb = ~pb;
        all_stop_low = ~stops[0] & ((ns == 1) | ~stops[1]);
        e.inst    = i;
        e.word    = masked;
        e.perr    = (pm != 0) & flip_par;
        e.ferr    = ~stops[0] | ((ns == 2) & ~stops[1]);
        e.brk     = (masked == 9'd0) & ((pm == 0) | ~pb) & all_stop_low;
        e.exp_cyc = cyc + 1 + 3 + h + n * c;
        if (expect_it) sb.push_back(e);
        sel = i;
        rx_line = 1'b0;
        repeat (c) @(negedge clk);
        for (int k = 0; k < nb; k++) begin
            rx_line = data[k];
            repeat (c) @(negedge clk);
        end
        if (pm != 0) begin
            rx_line = pb;
            repeat (c) @(negedge clk);
        end
        for (int k = 0; k < ns; k++) begin
            rx_line = stops[k];
            repeat (c) @(negedge clk);
        end
        if (tail_low > 0) begin
            rx_line = 1'b0;
            repeat (tail_low) @(negedge clk);
        end
        rx_line = 1'b1;
    endtask

    task automatic drain(input int maxc);
        int k;
        k = 0;
        while (sb.size() != 0 && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", sb.size(), 0);
    endtask

    task automatic chk_outputs_zero(input int i, input string tag);
        chk({tag, "_dv"}, 32'(dv[i]), 32'd0);
        chk({tag, "_word"}, 32'(wordx[i]), 32'd0);
        chk({tag, "_perr"}, 32'(perr[i]), 32'd0);
        chk({tag, "_ferr"}, 32'(ferr[i]), 32'd0);
        chk({tag, "_brk"}, 32'(brk[i]), 32'd0);
        chk({tag, "_busy"}, 32'(busy[i]), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        rx_line = 1'b1;
        sel = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) chk_outputs_zero(i, "reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 8N1 clean byte, then outputs must persist
        send_frame(0, 9'h0A5, 1'b0, 2'b11, 0, 1'b1);
        drain(100);
        repeat (20) @(negedge clk);
        chk("persist_word", 32'(word0), 32'h0A5);
        chk("persist_dv", 32'(dv[0]), 32'd0);
        chk("idle_busy", 32'(busy[0]), 32'd0);

        // Back-to-back frames with a one-bit idle gap at most
        send_frame(0, 9'h03C, 1'b0, 2'b11, 0, 1'b1);
        send_frame(0, 9'h0C3, 1'b0, 2'b11, 0, 1'b1);
        send_frame(0, 9'h000, 1'b0, 2'b11, 0, 1'b1);
        drain(100);

        // 8E1: wrong then correct parity
        send_frame(1, 9'h003, 1'b1, 2'b11, 0, 1'b1);
        send_frame(1, 9'h003, 1'b0, 2'b11, 0, 1'b1);
        send_frame(1, 9'h0FE, 1'b0, 2'b11, 0, 1'b1);
        drain(100);

        // 7O2: second stop low, line kept low, then recovery
        send_frame(2, 9'h055, 1'b0, 2'b01, 40, 1'b1);
        drain(100);
        chk("wait_high_busy", 32'(busy[2]), 32'd1);
        rx_line = 1'b1;
        repeat (6) @(negedge clk);
        chk("wait_high_release", 32'(busy[2]), 32'd0);
        send_frame(2, 9'h02A, 1'b0, 2'b11, 0, 1'b1);
        send_frame(2, 9'h07F, 1'b1, 2'b11, 0, 1'b1);
        drain(100);

        // 8N1 break: line low for three frame times
        send_frame(0, 9'h000, 1'b0, 2'b00, 320, 1'b1);
        drain(100);
        chk("break_wait_busy", 32'(busy[0]), 32'd1);
        rx_line = 1'b1;
        repeat (40) @(negedge clk);
        chk("break_release_busy", 32'(busy[0]), 32'd0);
        send_frame(0, 9'h081, 1'b0, 2'b11, 0, 1'b1);
        drain(100);

        // Short glitch on an idle line
        sel = 0;
        rx_line = 1'b0;
        repeat (5) @(negedge clk);
        chk("glitch_busy_high", 32'(busy[0]), 32'd1);
        rx_line = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_busy_low", 32'(busy[0]), 32'd0);

        // Reset in the middle of a 0xFF frame
        rx_line = 1'b0;
        repeat (16) @(negedge clk);
        rx_line = 1'b1;
        repeat (48) @(negedge clk);
        chk("pre_reset_busy", 32'(busy[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_outputs_zero(0, "mid_reset");
        rst = 1'b0;
        repeat (200) @(negedge clk);
        chk("post_reset_busy", 32'(busy[0]), 32'd0);

        // 9N1 with a wide bit counter
        send_frame(3, 9'h1C3, 1'b0, 2'b11, 0, 1'b1);
        drain(2000);

        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
